decode_stage: RTL and testbench

//  Decode stage of the 16-bit LC-3 pipeline. Drives the decode_out bus: IR, npc_out, E_control,
//  W_control, Mem_control and enable_decode toward Execute. Captures fetched instruction and

---
 rtl/decode_pkg.sv | 46 ++++
 rtl/decode_ctrl_lut.sv | 63 ++++++
 rtl/decode_stage.sv | 82 ++++++++
 tb/tb_decode_stage.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// decode_pkg: shared types and field encodings for the LC-3 decode stage.
//   op_e      - 4-bit LC-3 opcode (instr[15:12])
//   e_ctrl_t  - 6-bit Execute control word {alu, pcsel1, pcsel2, op2sel}
//   ALU_*, PCSEL1_*, WSEL_* - field encodings used to build the control words
package decode_pkg;

    typedef enum logic [3:0] {
        OP_BR   = 4'b0000,
        OP_ADD  = 4'b0001,
        OP_LD   = 4'b0010,
        OP_ST   = 4'b0011,
        OP_JSR  = 4'b0100,
        OP_AND  = 4'b0101,
        OP_LDR  = 4'b0110,
        OP_STR  = 4'b0111,
        OP_RTI  = 4'b1000,
        OP_NOT  = 4'b1001,
        OP_LDI  = 4'b1010,
        OP_STI  = 4'b1011,
        OP_JMP  = 4'b1100,
        OP_RES  = 4'b1101,
        OP_LEA  = 4'b1110,
        OP_TRAP = 4'b1111
    } op_e;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_AND = 2'b01;
    localparam logic [1:0] ALU_NOT = 2'b10;

    localparam logic [1:0] PCSEL1_NONE = 2'b00;
    localparam logic [1:0] PCSEL1_OFF9 = 2'b01;
    localparam logic [1:0] PCSEL1_OFF6 = 2'b10;
    localparam logic [1:0] PCSEL1_ZERO = 2'b11;

    localparam logic [1:0] WSEL_ALU = 2'b00;
    localparam logic [1:0] WSEL_MEM = 2'b01;
    localparam logic [1:0] WSEL_PC  = 2'b10;

    typedef struct packed {
        logic [1:0] alu;
        logic [1:0] pcsel1;
        logic       pcsel2;   // 1 = npc, 0 = base register
        logic       op2sel;   // 1 = register SR2, 0 = imm5
    } e_ctrl_t;

endpackage

// File: rtl/decode_ctrl_lut.sv
// decode_ctrl_lut: combinational opcode decode into control words.
//   instr  [15:0] in  - instruction being loaded
//   e_ctrl [5:0]  out - Execute control word
//   w_ctrl [1:0]  out - writeback select
//   m_ctrl        out - 1 for indirect memory access (LDI/STI)
module decode_ctrl_lut
    import decode_pkg::*;
(
    input  logic [15:0] instr,
    output e_ctrl_t     e_ctrl,
    output logic [1:0]  w_ctrl,
    output logic        m_ctrl
);

    // Only the opcode and the imm5 flag influence the controls.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr[11:6], instr[4:0]};

    always_comb begin
        e_ctrl = '0;
        w_ctrl = WSEL_ALU;
        m_ctrl = 1'b0;
        case (op_e'(instr[15:12]))
            OP_ADD: begin
                e_ctrl.alu    = ALU_ADD;
                e_ctrl.op2sel = ~instr[5];
            end
            OP_AND: begin
                e_ctrl.alu    = ALU_AND;
                e_ctrl.op2sel = ~instr[5];
            end
            OP_NOT: e_ctrl.alu = ALU_NOT;
            OP_BR, OP_ST: begin
                e_ctrl.pcsel1 = PCSEL1_OFF9;
                e_ctrl.pcsel2 = 1'b1;
            end
            OP_LD, OP_LDI: begin
                e_ctrl.pcsel1 = PCSEL1_OFF9;
                e_ctrl.pcsel2 = 1'b1;
                w_ctrl        = WSEL_MEM;
                m_ctrl        = (instr[15:12] == OP_LDI);
            end
            OP_STI: begin
                e_ctrl.pcsel1 = PCSEL1_OFF9;
                e_ctrl.pcsel2 = 1'b1;
                m_ctrl        = 1'b1;
            end
            OP_LEA: begin
                e_ctrl.pcsel1 = PCSEL1_OFF9;
                e_ctrl.pcsel2 = 1'b1;
                w_ctrl        = WSEL_PC;
            end
            OP_JMP: e_ctrl.pcsel1 = PCSEL1_ZERO;
            OP_LDR: begin
                e_ctrl.pcsel1 = PCSEL1_OFF6;
                w_ctrl        = WSEL_MEM;
            end
            OP_STR: e_ctrl.pcsel1 = PCSEL1_OFF6;
            default: ;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: LC-3 decode pipeline registers.
//   clock, reset (sync, active-high)
//   enable_decode        in  - load strobe for IR/npc/controls
//   instr_dout [15:0]    in  - fetched instruction
//   npc_in     [15:0]    in  - PC+1 from fetch
//   IR, npc_out [15:0]   out - registered instruction / PC+1
//   E_control [5:0], W_control [1:0], Mem_control - registered control words
//   enable_decode_out    out - enable_decode delayed one cycle
module decode_stage
    import decode_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        enable_decode,
    input  logic [15:0] instr_dout,
    input  logic [15:0] npc_in,
    output logic [15:0] IR,
    output logic [15:0] npc_out,
    output logic [5:0]  E_control,
    output logic [1:0]  W_control,
    output logic        Mem_control,
    output logic        enable_decode_out
);

    e_ctrl_t     lut_e;
    logic [1:0]  lut_w;
    logic        lut_m;

    logic [15:0] ir_q, ir_d, npc_q, npc_d;
    e_ctrl_t     e_q, e_d;
    logic [1:0]  w_q, w_d;
    logic        m_q, m_d, en_out_q, en_out_d;

    decode_ctrl_lut u_lut (
        .instr  (instr_dout),
        .e_ctrl (lut_e),
        .w_ctrl (lut_w),
        .m_ctrl (lut_m)
    );

    always_comb begin
        ir_d     = ir_q;
        npc_d    = npc_q;
        e_d      = e_q;
        w_d      = w_q;
        m_d      = m_q;
        en_out_d = enable_decode;
        if (enable_decode) begin
            ir_d  = instr_dout;
            npc_d = npc_in;
            e_d   = lut_e;
            w_d   = lut_w;
            m_d   = lut_m;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ir_q     <= '0;
            npc_q    <= '0;
            e_q      <= '0;
            w_q      <= '0;
            m_q      <= 1'b0;
            en_out_q <= 1'b0;
        end else begin
            ir_q     <= ir_d;
            npc_q    <= npc_d;
            e_q      <= e_d;
            w_q      <= w_d;
            m_q      <= m_d;
            en_out_q <= en_out_d;
        end
    end

    assign IR                = ir_q;
    assign npc_out           = npc_q;
    assign E_control         = e_q;
    assign W_control         = w_q;
    assign Mem_control       = m_q;
    assign enable_decode_out = en_out_q;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable_decode;
    logic [15:0] instr_dout;
    logic [15:0] npc_in;
    logic [15:0] IR;
    logic [15:0] npc_out;
    logic [5:0]  E_control;
    logic [1:0]  W_control;
    logic        Mem_control;
    logic        enable_decode_out;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [15:0] ir;
        logic [15:0] npc;
        logic [5:0]  e;
        logic [1:0]  w;
        logic        m;
        logic        en;
    } exp_t;

    exp_t exp_q[$];
    exp_t model;

    decode_stage dut (
        .clock             (clock),
        .reset             (reset),
        .enable_decode     (enable_decode),
        .instr_dout        (instr_dout),
        .npc_in            (npc_in),
        .IR                (IR),
        .npc_out           (npc_out),
        .E_control         (E_control),
        .W_control         (W_control),
        .Mem_control       (Mem_control),
        .enable_decode_out (enable_decode_out)
    );

    always #5 clock = ~clock;

    // Reference decode table, written directly from the instruction set.
    function automatic logic [8:0] ref_decode(input logic [15:0] i);
        logic [5:0] e;
        logic [1:0] w;
        logic       m;
        e = 6'b000000; w = 2'b00; m = 1'b0;
        case (i[15:12])
            4'b0001: e = {5'b00000, ~i[5]};
            4'b0101: e = {5'b01000, ~i[5]};
            4'b1001: e = 6'b100000;
            4'b0000: e = 6'b000110;
            4'b1100: e = 6'b001100;
            4'b0010: begin e = 6'b000110; w = 2'b01; end
            4'b1010: begin e = 6'b000110; w = 2'b01; m = 1'b1; end
            4'b0110: begin e = 6'b001000; w = 2'b01; end
            4'b0011: e = 6'b000110;
            4'b1011: begin e = 6'b000110; m = 1'b1; end
            4'b0111: e = 6'b001000;
            4'b1110: begin e = 6'b000110; w = 2'b10; end
            default: ;
        endcase
        return {e, w, m};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Drive one cycle of stimulus, push the expected outcome, then pop and compare after the edge.
    task automatic step(input logic rst, input logic en, input logic [15:0] ins, input logic [15:0] npc);
        exp_t got;
        logic [8:0] d;
        reset         = rst;
        enable_decode = en;
        instr_dout    = ins;
        npc_in        = npc;
        if (rst) begin
            model = '0;
        end else begin
            if (en) begin
                d         = ref_decode(ins);
                model.ir  = ins;
                model.npc = npc;
                model.e   = d[8:3];
                model.w   = d[2:1];
                model.m   = d[0];
            end
            model.en = en;
        end
        exp_q.push_back(model);
        @(posedge clock);
        #1;
        got = exp_q.pop_front();
        check("IR",          IR,                        got.ir);
        check("npc_out",     npc_out,                   got.npc);
        check("E_control",   {10'd0, E_control},        {10'd0, got.e});
        check("W_control",   {14'd0, W_control},        {14'd0, got.w});
        check("Mem_control", {15'd0, Mem_control},      {15'd0, got.m});
        check("enable_out",  {15'd0, enable_decode_out}, {15'd0, got.en});
    endtask

    initial begin
        model         = '0;
        reset         = 1'b1;
        enable_decode = 1'b1;
        instr_dout    = 16'h1283;
        npc_in        = 16'h3001;

        // Reset dominates a pending enable.
        step(1'b1, 1'b1, 16'h1283, 16'h3001);
        step(1'b1, 1'b1, 16'h1283, 16'h3001);

        // ADD register form, AND imm form, NOT.
        step(1'b0, 1'b1, 16'h1283, 16'h3001);
        step(1'b0, 1'b1, 16'h5020, 16'h3002);
        step(1'b0, 1'b1, 16'h903F, 16'h3003);

        // Indirect load, then LEA.
        step(1'b0, 1'b1, 16'hA405, 16'h3004);
        step(1'b0, 1'b1, 16'hE201, 16'h3005);

        // JMP loaded, then held for three cycles.
        step(1'b0, 1'b1, 16'hC1C0, 16'h3006);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 16'h1283, 16'h4000 + 16'(k));

        // Remaining opcodes, including ADD imm / AND register forms and unused opcodes.
        step(1'b0, 1'b1, 16'h1021, 16'h3100);
        step(1'b0, 1'b1, 16'h5042, 16'h3101);
        step(1'b0, 1'b1, 16'h0E05, 16'h3102);
        step(1'b0, 1'b1, 16'h2405, 16'h3103);
        step(1'b0, 1'b1, 16'h6643, 16'h3104);
        step(1'b0, 1'b1, 16'h3605, 16'h3105);
        step(1'b0, 1'b1, 16'hB605, 16'h3106);
        step(1'b0, 1'b1, 16'h7643, 16'h3107);
        step(1'b0, 1'b1, 16'h4800, 16'h3108);
        step(1'b0, 1'b1, 16'h8000, 16'h3109);
        step(1'b0, 1'b1, 16'hF025, 16'h310A);

        // Mid-stream reset coinciding with an enable, then the first load afterwards.
        step(1'b0, 1'b1, 16'hA405, 16'h3200);
        step(1'b1, 1'b1, 16'hD000, 16'h3201);
        step(1'b0, 1'b1, 16'hD000, 16'h3202);
        step(1'b0, 1'b0, 16'h1283, 16'h3203);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
